register_to_stream_multi: RTL and testbench

- Multi-channel, buffered successor to the single-register stream issuer.
- Sits on the server side of the piradip register interface, behind piradip_axi4mmlite_subordinate.
- Each of NUM_CHANNELS channels owns a FIFO_DEPTH-entry FIFO that feeds its own AXI4-Stream manager output.
- Software can queue several words per channel without polling, gets per-channel fill level and sticky overflow status, and can mark packet ends and flush a channel.

---
 rtl/register_to_stream_multi_if.sv | 43 ++++
 rtl/register_to_stream_multi.sv | 140 ++++++++++++++
 tb/tb_register_to_stream_multi.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/register_to_stream_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : register_to_stream_multi_if
// Description : Register-bus plus multi-channel AXI4-Stream bundle for
//               register_to_stream_multi.
//               Register side: wren/wreg_no/wreg_data/wstrb (write),
//               rden/rreg_no/rreg_data (read, rreg_data combinational).
//               Stream side  : m_tdata/m_tvalid/m_tlast per channel, m_tready
//               back from the consumers. failed_any is the sticky-error OR.
//               modport slave  : the register_to_stream_multi block.
//               modport master : whatever drives the register bus and sinks
//                                the streams.
// Revision    : 1.0 - initial release
// ============================================================================
interface register_to_stream_multi_if #(
    parameter int DATA_WIDTH         = 32,
    parameter int REGISTER_ADDR_BITS = 8,
    parameter int NUM_CHANNELS       = 4
);
    logic                             wren;
    logic [REGISTER_ADDR_BITS-1:0]    wreg_no;
    logic [DATA_WIDTH-1:0]            wreg_data;
    logic [DATA_WIDTH/8-1:0]          wstrb;
    logic                             rden;
    logic [REGISTER_ADDR_BITS-1:0]    rreg_no;
    logic [DATA_WIDTH-1:0]            rreg_data;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] m_tdata;
    logic [NUM_CHANNELS-1:0]          m_tvalid;
    logic [NUM_CHANNELS-1:0]          m_tlast;
    logic [NUM_CHANNELS-1:0]          m_tready;
    logic                             failed_any;

    modport slave (
        input  wren, wreg_no, wreg_data, wstrb, rden, rreg_no, m_tready,
        output rreg_data, m_tdata, m_tvalid, m_tlast, failed_any
    );

    modport master (
        output wren, wreg_no, wreg_data, wstrb, rden, rreg_no, m_tready,
        input  rreg_data, m_tdata, m_tvalid, m_tlast, failed_any
    );
endinterface
`default_nettype wire

// File: rtl/register_to_stream_multi.sv
`default_nettype none
// ============================================================================
// Module      : register_to_stream_multi
// Description : Register-mapped multi-channel stream issuer. Every channel
//               owns a show-ahead FIFO of FIFO_DEPTH words (each word carries
//               its tlast bit) feeding its own AXI4-Stream output.
//               Channel c register block at BASE_REG+4c:
//                 +0 DATA      write pushes {tlast=0, data}
//                 +1 DATA_LAST write pushes {tlast=1, data}
//                 +2 STATUS    read: [0] empty [1] full [2] failed [15:8] level
//                 +3 CONTROL   write: bit0 clear failed, bit1 flush
// Ports       : aclk    - clock
//               aresetn - asynchronous active-low reset
//               bus     - register bus + stream bundle (slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
module register_to_stream_multi #(
    parameter int DATA_WIDTH         = 32,
    parameter int REGISTER_ADDR_BITS = 8,
    parameter int NUM_CHANNELS       = 4,
    parameter int FIFO_DEPTH         = 4,
    parameter int BASE_REG           = 0
) (
    input  wire logic                  aclk,
    input  wire logic                  aresetn,
    register_to_stream_multi_if.slave  bus
);
    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_LEVEL_W = c_PTR_W + 1;

    logic [DATA_WIDTH-1:0]   w_status [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] w_failed;

    // A push needs every byte lane; anything less is a software error.
    logic w_strb_full;
    assign w_strb_full = &bus.wstrb;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        localparam logic [REGISTER_ADDR_BITS-1:0] c_ADDR_DATA   = REGISTER_ADDR_BITS'(BASE_REG + 4*c);
        localparam logic [REGISTER_ADDR_BITS-1:0] c_ADDR_LAST   = REGISTER_ADDR_BITS'(BASE_REG + 4*c + 1);
        localparam logic [REGISTER_ADDR_BITS-1:0] c_ADDR_STATUS = REGISTER_ADDR_BITS'(BASE_REG + 4*c + 2);
        localparam logic [REGISTER_ADDR_BITS-1:0] c_ADDR_CTRL   = REGISTER_ADDR_BITS'(BASE_REG + 4*c + 3);

        // Each entry is {tlast, data}.
        logic [DATA_WIDTH:0]    r_mem [FIFO_DEPTH];
        logic [c_PTR_W-1:0]     r_wr_ptr;
        logic [c_PTR_W-1:0]     r_rd_ptr;
        logic [c_LEVEL_W-1:0]   r_level;
        logic                   r_failed;

        logic w_hit_data;
        logic w_hit_last;
        logic w_hit_ctrl;
        logic w_push_req;
        logic w_full;
        logic w_empty;
        logic w_flush;
        logic w_clr;
        logic w_push;
        logic w_reject;
        logic w_pop;

        assign w_hit_data = bus.wren && (bus.wreg_no == c_ADDR_DATA);
        assign w_hit_last = bus.wren && (bus.wreg_no == c_ADDR_LAST);
        assign w_hit_ctrl = bus.wren && (bus.wreg_no == c_ADDR_CTRL);
        assign w_push_req = w_hit_data | w_hit_last;

        assign w_full  = (r_level == c_LEVEL_W'(FIFO_DEPTH));
        assign w_empty = (r_level == '0);

        assign w_flush = w_hit_ctrl & bus.wstrb[0] & bus.wreg_data[1];
        assign w_clr   = (w_hit_ctrl & bus.wstrb[0] & bus.wreg_data[0])
                       | (bus.rden && (bus.rreg_no == c_ADDR_STATUS));

        // Fullness is judged on the registered level, so a pop in the same
        // cycle does not make room for a push. A push coinciding with a flush
        // is silently dropped rather than flagged.
        assign w_reject = w_push_req & ~w_flush & (~w_strb_full | w_full);
        assign w_push   = w_push_req & ~w_flush & w_strb_full & ~w_full;
        assign w_pop    = ~w_empty & bus.m_tready[c] & ~w_flush;

        // Storage needs no reset: outputs are masked to zero while empty.
        always_ff @(posedge aclk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_hit_last, bus.wreg_data};
            end
        end

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
                r_failed <= 1'b0;
            end else begin
                // Set has priority over clear.
                r_failed <= w_reject | (r_failed & ~w_clr);
                if (w_flush) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_level  <= '0;
                end else begin
                    if (w_push) begin
                        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                    end
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                    end
                    case ({w_push, w_pop})
                        2'b10:   r_level <= r_level + c_LEVEL_W'(1);
                        2'b01:   r_level <= r_level - c_LEVEL_W'(1);
                        default: r_level <= r_level;
                    endcase
                end
            end
        end

        assign bus.m_tvalid[c] = ~w_empty;
        assign bus.m_tdata[c*DATA_WIDTH +: DATA_WIDTH] =
            w_empty ? '0 : r_mem[r_rd_ptr][DATA_WIDTH-1:0];
        assign bus.m_tlast[c] = w_empty ? 1'b0 : r_mem[r_rd_ptr][DATA_WIDTH];

        assign w_status[c] = DATA_WIDTH'({8'(r_level), 5'b0, r_failed, w_full, w_empty});
        assign w_failed[c] = r_failed;
    end

    // Only STATUS registers read back; every other address returns zero.
    always_comb begin
        bus.rreg_data = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (bus.rreg_no == REGISTER_ADDR_BITS'(BASE_REG + 4*c + 2)) begin
                bus.rreg_data = w_status[c];
            end
        end
    end

    assign bus.failed_any = |w_failed;

endmodule
`default_nettype wire

// File: tb/tb_register_to_stream_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_to_stream_multi
// Description : Directed self-checking bench for register_to_stream_multi
//               (4 channels x 4-deep FIFOs, 32-bit data, BASE_REG 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_to_stream_multi;
    logic aclk;
    logic aresetn;
    int   n_err;
    int   n_checks;

    register_to_stream_multi_if #(
        .DATA_WIDTH(32), .REGISTER_ADDR_BITS(8), .NUM_CHANNELS(4)
    ) bus ();

    register_to_stream_multi #(
        .DATA_WIDTH(32), .REGISTER_ADDR_BITS(8), .NUM_CHANNELS(4),
        .FIFO_DEPTH(4), .BASE_REG(0)
    ) u_dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one register write for exactly one clock; returns at the next
    // falling edge with wren low again.
    task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bus.wren      = 1'b1;
        bus.wreg_no   = addr;
        bus.wreg_data = data;
        bus.wstrb     = strb;
        @(negedge aclk);
        bus.wren      = 1'b0;
    endtask

    // Non-clearing look at a register (rden low).
    task automatic peek(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        bus.rden    = 1'b0;
        bus.rreg_no = addr;
        #1;
        chk(tag, 128'(bus.rreg_data), 128'(exp));
    endtask

    // Real read strobe (clears failed on STATUS); held for one clock.
    task automatic rd(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        bus.rden    = 1'b1;
        bus.rreg_no = addr;
        #1;
        chk(tag, 128'(bus.rreg_data), 128'(exp));
        @(negedge aclk);
        bus.rden    = 1'b0;
    endtask

    initial begin
        n_err         = 0;
        n_checks      = 0;
        aresetn       = 1'b1;
        bus.wren      = 1'b0;
        bus.wreg_no   = '0;
        bus.wreg_data = '0;
        bus.wstrb     = '0;
        bus.rden      = 1'b0;
        bus.rreg_no   = '0;
        bus.m_tready  = 4'b0001;
        #1 aresetn = 1'b0;
        repeat (2) @(negedge aclk);

        // Reset state
        chk("rst_tvalid", 128'(bus.m_tvalid), 128'(0));
        chk("rst_tlast", 128'(bus.m_tlast), 128'(0));
        chk("rst_tdata", bus.m_tdata, 128'(0));
        chk("rst_failed_any", 128'(bus.failed_any), 128'(0));
        peek("rst_status0", 8'd2, 32'h0000_0001);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        // Single word on ch0, consumer ready: visible for exactly one cycle
        bus.wren = 1'b1; bus.wreg_no = 8'd0; bus.wreg_data = 32'h1122_3344; bus.wstrb = 4'hF;
        #1 chk("ch0_not_same_cycle", 128'(bus.m_tvalid[0]), 128'(0));
        @(negedge aclk);
        bus.wren = 1'b0;
        chk("ch0_valid", 128'(bus.m_tvalid[0]), 128'(1));
        chk("ch0_data", 128'(bus.m_tdata[31:0]), 128'(32'h1122_3344));
        chk("ch0_last", 128'(bus.m_tlast[0]), 128'(0));
        @(negedge aclk);
        chk("ch0_popped", 128'(bus.m_tvalid[0]), 128'(0));
        peek("ch0_status_empty", 8'd2, 32'h0000_0001);

        // ch1 stalled: fill, overflow, sticky flag, clearing read
        bus.m_tready[1] = 1'b0;
        for (int i = 0; i < 4; i++) wr(8'd4, 32'hA0 + 32'(i), 4'hF);
        peek("ch1_status_full", 8'd6, 32'h0000_0402);
        chk("ch1_head_stalled", 128'(bus.m_tdata[63:32]), 128'(32'hA0));
        wr(8'd4, 32'hA4, 4'hF);
        peek("ch1_status_ovf", 8'd6, 32'h0000_0406);
        chk("ch1_failed_any", 128'(bus.failed_any), 128'(1));
        chk("ch1_head_still", 128'(bus.m_tdata[63:32]), 128'(32'hA0));
        rd("ch1_clear_read", 8'd6, 32'h0000_0406);
        peek("ch1_reread", 8'd6, 32'h0000_0402);
        chk("ch1_failed_any_clr", 128'(bus.failed_any), 128'(0));
        bus.m_tready[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ch1_drain_v%0d", i), 128'(bus.m_tvalid[1]), 128'(1));
            chk($sformatf("ch1_drain_d%0d", i), 128'(bus.m_tdata[63:32]), 128'(32'hA0 + 32'(i)));
            @(negedge aclk);
        end
        chk("ch1_drained", 128'(bus.m_tvalid[1]), 128'(0));

        // ch2: DATA then DATA_LAST on consecutive cycles
        bus.m_tready[2] = 1'b1;
        wr(8'd8, 32'h1, 4'hF);
        chk("ch2_beat0_v", 128'(bus.m_tvalid[2]), 128'(1));
        chk("ch2_beat0_d", 128'(bus.m_tdata[95:64]), 128'(32'h1));
        chk("ch2_beat0_l", 128'(bus.m_tlast[2]), 128'(0));
        wr(8'd9, 32'h2, 4'hF);
        chk("ch2_beat1_v", 128'(bus.m_tvalid[2]), 128'(1));
        chk("ch2_beat1_d", 128'(bus.m_tdata[95:64]), 128'(32'h2));
        chk("ch2_beat1_l", 128'(bus.m_tlast[2]), 128'(1));
        @(negedge aclk);
        chk("ch2_done", 128'(bus.m_tvalid[2]), 128'(0));

        // ch3: push at full while a pop happens is still rejected
        bus.m_tready[3] = 1'b0;
        for (int i = 0; i < 4; i++) wr(8'd12, 32'h30 + 32'(i), 4'hF);
        peek("ch3_full", 8'd14, 32'h0000_0402);
        bus.m_tready[3] = 1'b1;
        wr(8'd12, 32'h34, 4'hF);
        bus.m_tready[3] = 1'b0;
        peek("ch3_pop_push_full", 8'd14, 32'h0000_0304);
        chk("ch3_head", 128'(bus.m_tdata[127:96]), 128'(32'h31));
        wr(8'd15, 32'h3, 4'hF);
        peek("ch3_flush_clear", 8'd14, 32'h0000_0001);

        // Partial strobe on ch0 and CONTROL clear
        wr(8'd0, 32'hDEAD, 4'b0011);
        chk("ch0_partial_nopush", 128'(bus.m_tvalid[0]), 128'(0));
        peek("ch0_partial_failed", 8'd2, 32'h0000_0005);
        wr(8'd3, 32'h1, 4'b1110);
        peek("ch0_ctrl_nostrb", 8'd2, 32'h0000_0005);
        wr(8'd3, 32'h1, 4'hF);
        peek("ch0_ctrl_clear", 8'd2, 32'h0000_0001);
        chk("failed_any_clear", 128'(bus.failed_any), 128'(0));

        // ch1 flush with 3 words queued
        bus.m_tready[1] = 1'b0;
        for (int i = 0; i < 3; i++) wr(8'd4, 32'hB0 + 32'(i), 4'hF);
        peek("ch1_level3", 8'd6, 32'h0000_0300);
        wr(8'd7, 32'h2, 4'hF);
        chk("ch1_flush_valid", 128'(bus.m_tvalid[1]), 128'(0));
        chk("ch1_flush_data", 128'(bus.m_tdata[63:32]), 128'(0));
        peek("ch1_flush_status", 8'd6, 32'h0000_0001);

        // Non-STATUS and out-of-range reads
        peek("read_data_reg", 8'd4, 32'h0);
        peek("read_out_of_range", 8'd16, 32'h0);

        // Asynchronous reset mid-stream
        bus.m_tready[0] = 1'b0;
        wr(8'd0, 32'h55, 4'hF);
        chk("ch0_pre_rst", 128'(bus.m_tvalid[0]), 128'(1));
        #2 aresetn = 1'b0;
        #1;
        chk("async_rst_valid", 128'(bus.m_tvalid), 128'(0));
        chk("async_rst_data", bus.m_tdata, 128'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("post_rst_valid", 128'(bus.m_tvalid), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
